seq_adder: RTL

SEQ_ADDER -- requirements
Module: seq_adder

---
 rtl/seq_adder_pkg.sv | 21 ++
 rtl/seq_adder_add_chunk.sv | 37 +++
 rtl/seq_adder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/seq_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_adder_pkg
//  Brief    : Shared constants and FSM state type for the chunked serial
//             adder/subtractor.
//  Revision : 1.0 - initial release
// ============================================================================
package seq_adder_pkg;

    localparam int c_default_width = 16;
    localparam int c_default_chunk = 4;

    // Operation lifecycle: waiting for a request, rippling chunks, holding result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : seq_adder_pkg
`default_nettype wire

// File: rtl/seq_adder_add_chunk.sv
`default_nettype none
// ============================================================================
//  Module   : add_chunk
//  Brief    : Combinational CHUNK-bit ripple-carry adder built from full-adder
//             cells. Also exposes the carry into its top bit so the caller can
//             derive two's-complement overflow on the final chunk.
//  Revision : 1.0 - initial release
// ============================================================================
module add_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             ctop
);

    // w_c[i] is the carry into bit i; w_c[CHUNK] is the carry out of the chunk
    logic [CHUNK:0] w_c;

    assign w_c[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < CHUNK; gi = gi + 1) begin : g_fa
            assign s[gi]     = a[gi] ^ b[gi] ^ w_c[gi];
            assign w_c[gi+1] = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = w_c[CHUNK];
    assign ctop = w_c[CHUNK-1];

endmodule : add_chunk
`default_nettype wire

// File: rtl/seq_adder.sv
`default_nettype none
// ============================================================================
//  Module   : seq_adder
//  Brief    : Multi-cycle WIDTH-bit adder/subtractor that processes CHUNK bits
//             per clock, LSB chunk first, with valid/ready handshakes on both
//             the request and result sides. One operation in flight at a time.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int CHUNK = c_default_chunk
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_x,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_s,
    output logic             o_c,
    output logic             o_v
);

    // Refuse to build with a chunk size that does not tile the word
    generate
        if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $error("seq_adder: CHUNK must be >= 1 and divide WIDTH");
        end
    endgenerate

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] c_last_cnt = CW'(N - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_work;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_s;
    logic             r_c;
    logic             r_v;

    logic             w_accept;
    logic             w_last;
    logic [CHUNK-1:0] w_sum;
    logic             w_cout;
    logic             w_ctop;
    logic [WIDTH-1:0] w_work_next;

    assign o_ready  = (r_state == IDLE) && !i_rst;
    assign o_valid  = (r_state == DONE);
    assign o_s      = r_s;
    assign o_c      = r_c;
    assign o_v      = r_v;

    assign w_accept = i_valid && o_ready;
    assign w_last   = (r_state == RUN) && (r_cnt == c_last_cnt);

    // Operands are shifted right each RUN cycle, so the active chunk is
    // always the low CHUNK bits of the operand registers.
    add_chunk #(
        .CHUNK (CHUNK)
    ) u_add_chunk (
        .a    (r_a[CHUNK-1:0]),
        .b    (r_b[CHUNK-1:0]),
        .cin  (r_carry),
        .s    (w_sum),
        .cout (w_cout),
        .ctop (w_ctop)
    );

    // New sum chunk enters at the top; after N cycles chunk 0 sits at the LSB
    assign w_work_next = (r_work >> CHUNK) | (WIDTH'(w_sum) << (WIDTH - CHUNK));

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept -> ripple N chunks -> hold until drained
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = RUN;
            RUN:     if (w_last)   w_state_next = DONE;
            DONE:    if (i_ready)  w_state_next = IDLE;
            default:               w_state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, ripple one chunk per RUN cycle,
    // publish the result only on the final chunk so outputs hold otherwise
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_work  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
        end else begin
            if (w_accept) begin
                // Subtraction is A + ~B + ~x, so invert B and the carry-in
                r_a     <= i_a;
                r_b     <= i_sub ? ~i_b : i_b;
                r_carry <= i_x ^ i_sub;
                r_cnt   <= '0;
            end else if (r_state == RUN) begin
                r_a     <= r_a >> CHUNK;
                r_b     <= r_b >> CHUNK;
                r_work  <= w_work_next;
                r_carry <= w_cout;
                if (w_last) begin
                    r_s <= w_work_next;
                    r_c <= w_cout;
                    r_v <= w_cout ^ w_ctop;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

endmodule : seq_adder
`default_nettype wire
